// File: rtl/max7219_scheduler_pkg.sv
// Shared stopwatch display definitions: scheduler state encoding, MAX7219
// register map and the job/digit types used by the refresh scheduler.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'b000,
        ST_IDLE = 3'b100,
        ST_LOAD = 3'b101,
        ST_XFER = 3'b110,
        ST_GAP  = 3'b111
    } state_t;

    typedef enum logic [1:0] {
        JOB_INIT      = 2'd0,
        JOB_INTENSITY = 2'd1,
        JOB_FRAME     = 2'd2
    } job_t;

    localparam logic [7:0] REG_DECODE     = 8'h09;
    localparam logic [7:0] REG_INTENSITY  = 8'h0A;
    localparam logic [7:0] REG_SCAN_LIMIT = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN   = 8'h0C;
    localparam logic [7:0] DIGIT_DP       = 8'h80;

    localparam int GAP_CYCLES_DEFAULT = 32;

    typedef struct packed {
        logic [3:0] ces_0X;
        logic [3:0] ces_X0;
        logic [3:0] sec_0X;
        logic [2:0] sec_X0;
        logic [3:0] min_0X;
        logic [2:0] min_X0;
    } digits_t;

    // Index of the final word of each job; the job ends after this word's gap.
    function automatic logic [2:0] job_last_idx(job_t job);
        case (job)
            JOB_INIT:  return 3'd3;
            JOB_FRAME: return 3'd5;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/max7219_scheduler_if.sv
// SPI word handshake between the display scheduler and the SPI shift master.
interface max7219_scheduler_if;
    logic        spi_ready;
    logic        spi_sent;
    logic [15:0] spi_word;
    logic        spi_cs;

    modport master (input spi_ready, spi_sent, output spi_word, spi_cs);
    modport slave  (output spi_ready, spi_sent, input spi_word, spi_cs);
endinterface

// File: rtl/max7219_word_gen.sv
// Maps (job, word index, digit snapshot, intensity) to the 16-bit MAX7219
// command word {addr, data}.
module max7219_word_gen
    import stopwatch_pkg::*;
(
    input  job_t        job,
    input  logic [2:0]  word_idx,
    input  digits_t     digits,
    input  logic [3:0]  intensity,
    output logic [15:0] word
);

    always_comb begin
        word = 16'h0000;
        case (job)
            JOB_INIT: begin
                case (word_idx)
                    3'd0:    word = {REG_SHUTDOWN, 8'h01};
                    3'd1:    word = {REG_DECODE, 8'hFF};
                    3'd2:    word = {REG_SCAN_LIMIT, 8'h05};
                    default: word = {REG_INTENSITY, 4'h0, intensity};
                endcase
            end
            JOB_INTENSITY: word = {REG_INTENSITY, 4'h0, intensity};
            JOB_FRAME: begin
                // Digit registers are 0x01..0x06; the decimal point marks the
                // seconds and minutes units digits.
                word[15:8] = {5'd0, word_idx} + 8'd1;
                case (word_idx)
                    3'd0:    word[7:0] = {4'h0, digits.ces_0X};
                    3'd1:    word[7:0] = {4'h0, digits.ces_X0};
                    3'd2:    word[7:0] = {4'h0, digits.sec_0X} | DIGIT_DP;
                    3'd3:    word[7:0] = {5'h00, digits.sec_X0};
                    3'd4:    word[7:0] = {4'h0, digits.min_0X} | DIGIT_DP;
                    default: word[7:0] = {5'h00, digits.min_X0};
                endcase
            end
            default: word = 16'h0000;
        endcase
    end

endmodule

// File: rtl/max7219_scheduler.sv
// MAX7219 refresh scheduler: sends the init sequence after reset, then serves
// intensity writes and 6-digit frame refreshes one SPI word at a time.
module max7219_scheduler
    import stopwatch_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
)
(
    input  logic                      clk,
    input  logic                      res,
    input  logic                      tick,
    input  logic                      ena,
    input  logic [3:0]                ces_0X,
    input  logic [3:0]                ces_X0,
    input  logic [3:0]                sec_0X,
    input  logic [2:0]                sec_X0,
    input  logic [3:0]                min_0X,
    input  logic [2:0]                min_X0,
    input  logic [3:0]                intensity,
    input  logic                      intensity_req,
    max7219_scheduler_if.master       spi,
    output logic                      busy,
    output logic                      overrun,
    output logic [2:0]                state_out
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t            state;
    job_t              job;
    logic [2:0]        word_idx;
    logic [GAP_W-1:0]  gap_cnt;
    digits_t           digits_live;
    digits_t           snap;
    logic [3:0]        int_lat;
    logic [3:0]        int_job;
    logic              refresh_pending;
    logic              intensity_pending;
    logic              start_int;
    logic              start_frame;
    logic [15:0]       next_word;

    assign digits_live = {ces_0X, ces_X0, sec_0X, sec_X0, min_0X, min_X0};
    assign start_int   = (state == ST_IDLE) && intensity_pending;
    assign start_frame = (state == ST_IDLE) && !intensity_pending && refresh_pending;
    assign state_out   = state;

    max7219_word_gen u_word_gen (
        .job       (job),
        .word_idx  (word_idx),
        .digits    (snap),
        .intensity (int_job),
        .word      (next_word)
    );

    // Request flags: a new request in the cycle its job starts re-arms the flag.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            refresh_pending   <= 1'b0;
            intensity_pending <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            overrun <= tick && ena && refresh_pending && !start_frame;
            if (tick && ena) begin
                refresh_pending <= 1'b1;
            end else if (start_frame) begin
                refresh_pending <= 1'b0;
            end
            if (intensity_req) begin
                intensity_pending <= 1'b1;
            end else if (start_int) begin
                intensity_pending <= 1'b0;
            end
        end
    end

    // Job data: latched request value, per-job intensity and frame snapshot.
    always_ff @(posedge clk) begin
        if (intensity_req) begin
            int_lat <= intensity;
        end
        if (start_frame) begin
            snap <= digits_live;
        end
        if (state == ST_INIT) begin
            int_job <= intensity;
        end else if (start_int) begin
            int_job <= int_lat;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state        <= ST_INIT;
            job          <= JOB_INIT;
            word_idx     <= 3'd0;
            gap_cnt      <= '0;
            spi.spi_word <= 16'h0000;
            spi.spi_cs   <= 1'b1;
            busy         <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    job      <= JOB_INIT;
                    word_idx <= 3'd0;
                    state    <= ST_LOAD;
                end
                ST_IDLE: begin
                    if (start_int) begin
                        job      <= JOB_INTENSITY;
                        word_idx <= 3'd0;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end else if (start_frame) begin
                        job      <= JOB_FRAME;
                        word_idx <= 3'd0;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (spi.spi_ready) begin
                        spi.spi_word <= next_word;
                        spi.spi_cs   <= 1'b0;
                        state        <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (spi.spi_sent) begin
                        spi.spi_cs <= 1'b1;
                        gap_cnt    <= '0;
                        state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (word_idx == job_last_idx(job)) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            word_idx <= word_idx + 3'd1;
                            state    <= ST_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b1;
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
